// File: rtl/fsm_event_pkg.sv
// Shared event codes and sequencer state encodings for the sleep/wake FSM
// and its upstream event sequencer.
package fsm_event_pkg;

   localparam int INPUT_SIZE = 3;

   localparam logic [2:0] I_NONE         = 3'b000;
   localparam logic [2:0] I_GETTIRED     = 3'b001;
   localparam logic [2:0] I_GETVERYTIRED = 3'b010;
   localparam logic [2:0] I_TRANQUILIZER = 3'b011;
   localparam logic [2:0] I_TIMEFORCLASS = 3'b100;
   localparam logic [2:0] I_LOUDNOISE    = 3'b101;
   localparam logic [2:0] I_ALARMCLOCK   = 3'b110;
   localparam logic [2:0] I_COLDWATER    = 3'b111;

   // Lines at or above this index are wake-up events.
   localparam int WAKE_LO = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } seq_state_e;

endpackage

// File: rtl/fsm_event_prio_enc.sv
// Pending-to-grant encoder: any wake-up line beats every sleep line,
// and the highest index wins inside a group.
module fsm_event_prio_enc #(
   parameter int NUM_EVENTS = 7,
   parameter int INPUT_SIZE = 3
) (
   input  logic [NUM_EVENTS-1:0] pend_i,
   output logic [NUM_EVENTS-1:0] grant_o,
   output logic [INPUT_SIZE-1:0] code_o,
   output logic                  valid_o
);
   import fsm_event_pkg::*;

   logic [NUM_EVENTS-1:0] wake;
   logic [NUM_EVENTS-1:0] sleep;

   always_comb begin
      wake  = '0;
      sleep = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (i >= WAKE_LO) begin
            wake[i] = pend_i[i];
         end else begin
            sleep[i] = pend_i[i];
         end
      end
   end

   // Ascending scan: the last hit is the highest index.
   always_comb begin
      grant_o = '0;
      code_o  = '0;
      if (|wake) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            if (wake[i]) begin
               grant_o    = '0;
               grant_o[i] = 1'b1;
               code_o     = INPUT_SIZE'(i + 1);
            end
         end
      end else begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            if (sleep[i]) begin
               grant_o    = '0;
               grant_o[i] = 1'b1;
               code_o     = INPUT_SIZE'(i + 1);
            end
         end
      end
   end

   assign valid_o = |pend_i;

endmodule

// File: rtl/fsm_event_sequencer.sv
// Turns raw stimulus levels into single, spaced event codes for the FSM.
// Define FSM_EVENT_SYNC_EN to add a 2-flop synchronizer on stim_in.
module fsm_event_sequencer #(
   parameter int INPUT_SIZE  = 3,
   parameter int NUM_EVENTS  = 7,
   parameter int HOLD_CYCLES = 1,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] stim_in,
   output logic [INPUT_SIZE-1:0] event_out,
   output logic                  event_valid,
   output logic [NUM_EVENTS-1:0] pending,
   output logic                  overflow,
   output logic                  busy
);
   import fsm_event_pkg::*;

   logic [NUM_EVENTS-1:0] stim_s;
   logic [NUM_EVENTS-1:0] stim_q;
   logic [NUM_EVENTS-1:0] rise;
   logic [NUM_EVENTS-1:0] pend_q, pend_d;
   logic [NUM_EVENTS-1:0] grant;
   logic [NUM_EVENTS-1:0] clr;
   logic [INPUT_SIZE-1:0] code;
   logic [INPUT_SIZE-1:0] ev_q, ev_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;
   logic                  req_any;
   logic                  cnt_zero;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   seq_state_e            state_q, state_d;

`ifdef FSM_EVENT_SYNC_EN
   logic [NUM_EVENTS-1:0] sync1_q;
   logic [NUM_EVENTS-1:0] sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= stim_in;
         sync2_q <= sync1_q;
      end
   end

   assign stim_s = sync2_q;
`else
   assign stim_s = stim_in;
`endif

   fsm_event_prio_enc #(
      .NUM_EVENTS (NUM_EVENTS),
      .INPUT_SIZE (INPUT_SIZE)
   ) u_prio (
      .pend_i  (pend_q),
      .grant_o (grant),
      .code_o  (code),
      .valid_o (req_any)
   );

   assign cnt_zero = (cnt_q == '0);

   // A rise on a bit being granted keeps it set and is not an overflow.
   always_comb begin
      rise   = stim_s & ~stim_q;
      pend_d = (pend_q & ~clr) | rise;
      ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         stim_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         ev_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stim_q  <= stim_s;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         ev_q    <= ev_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               state_d = S_ISSUE;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         S_ISSUE: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (GAP_CYCLES > 0) begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end else if (req_any) begin
               state_d = S_ISSUE;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      clr     = '0;
      ev_d    = ev_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               clr     = grant;
               ev_d    = code;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               ev_d    = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         S_ISSUE: begin
            if (!cnt_zero) begin
               ev_d = ev_q;
            end else if (GAP_CYCLES > 0) begin
               ev_d    = '0;
               valid_d = 1'b0;
            end else if (req_any) begin
               clr     = grant;
               ev_d    = code;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               ev_d    = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         S_GAP: begin
            ev_d    = '0;
            valid_d = 1'b0;
            if (cnt_zero) begin
               busy_d = 1'b0;
            end
         end
         default: begin
            ev_d    = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign event_out   = ev_q;
   assign event_valid = valid_q;
   assign pending     = pend_q;
   assign overflow    = ovf_q;
   assign busy        = busy_q;

endmodule

// File: doc/fsm_event_sequencer.md
Name: fsm_event_sequencer

Overview:
- Upstream stage of the sleep/wake FSM. Converts raw, level-type stimulus lines into single, spaced 3-bit event codes on the FSM's input bus.
- Detects rising edges and holds each one as a pending request. Arbitrates by fixed priority, with wake-up events beating go-to-sleep events.
- Drives each code for HOLD_CYCLES, then drives the null code 3'b000 for GAP_CYCLES, so the consumer sees every event as a distinct input.

Parameters:
- INPUT_SIZE, 3, width of the event code; matches the FSM input width.
- NUM_EVENTS, 7, number of stimulus lines. Line i maps to event code i+1.
- HOLD_CYCLES, 1, cycles each code is driven (>=1).
- GAP_CYCLES, 1, null-code cycles after each code (>=0).
- CNT_W, 4, width of the hold/gap counter. Must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stim_in  input  NUM_EVENTS  raw stimulus levels. bit0=GETTIRED, bit1=GETVERYTIRED, bit2=TRANQUILIZER, bit3=TIMEFORCLASS, bit4=LOUDNOISE, bit5=ALARMCLOCK, bit6=COLDWATER.
- event_out  output  INPUT_SIZE  event code to the FSM; 3'b000 when idle or in gap.
- event_valid  output  1  high while event_out carries a real code.
- pending  output  NUM_EVENTS  outstanding requests.
- overflow  output  1  sticky; a request re-arrived while already pending.
- busy  output  1  high in S_ISSUE or S_GAP.

Behaviour:
- Reset (async assert): stim_q=0, pending=0, overflow=0, counter=0, state=S_IDLE, event_out=3'b000, event_valid=0, busy=0. All outputs are registered.
- Edge detect: rise = stim_in & ~stim_q. stim_q <= stim_in every cycle. A level held high counts as one request only.
- Pending update each cycle: pending <= (pending & ~clr) | rise.
  - clr is the one-hot grant issued this cycle.
  - If rise and clr hit the same bit in the same cycle, the bit stays set (set wins) and is not counted as an overflow.
- Overflow: set when rise & pending & ~clr is nonzero. Cleared only by reset.
- Priority encoder:
  - Any of bits 6..3 pending: the highest-index such bit wins.
  - Otherwise the highest of bits 2..0 wins.
  - Result: code = index+1, grant one-hot.
- FSM states:
  - S_IDLE:
    - If pending is nonzero: clr=grant, event_out<=code, event_valid<=1, busy<=1, counter<=HOLD_CYCLES-1, go to S_ISSUE.
    - Otherwise stay; event_out=000.
  - S_ISSUE:
    - If counter>0: decrement and keep the code.
    - Else if GAP_CYCLES>0: event_out<=000, event_valid<=0, counter<=GAP_CYCLES-1, go to S_GAP.
    - Else behave as S_IDLE this cycle (a back-to-back grant is allowed; otherwise go to S_IDLE with outputs cleared).
  - S_GAP:
    - If counter>0: decrement.
    - Else: busy<=0, go to S_IDLE.
  - Undefined state encodings: return to S_IDLE and drive 000.
- Latency: a stim rise sampled at edge k sets pending at k. With the block idle, the code appears after edge k+1.
- Throughput: one event per HOLD_CYCLES+GAP_CYCLES+1 cycles (3 at defaults).
- Arbitration happens only on entry to S_ISSUE. Requests arriving during ISSUE or GAP wait in pending; they never pre-empt the code being issued.
- Async reset mid-issue: event_out drops to 000 immediately and all pending requests are lost.

Optional Feature:
- Macro: FSM_EVENT_SYNC_EN.
- Defined: stim_in passes through a 2-flop synchronizer (reset to 0) before edge detection. Latency grows by 2 cycles. Use for asynchronous stimulus sources.
- Undefined: stim_in feeds edge detection directly; the source must already be in the clk domain.

Decomposition:
- Shared package fsm_event_pkg holds:
  - INPUT_SIZE and the event code constants I_GETTIRED..I_COLDWATER plus I_NONE=3'b000, shared with the sleep/wake FSM;
  - the sequencer state encodings S_IDLE/S_ISSUE/S_GAP.
- One sub-module: fsm_event_prio_enc, a combinational pending-to-grant/code encoder implementing the wake-over-sleep rule.

Test Plan:
- Reset check: assert reset mid-cycle while in S_ISSUE with code 3'b110 → event_out=000, event_valid=0, pending=0 asynchronously; after release, stays idle with stim_in=0.
- Single request: stim_in=7'b0000010 held 10 cycles → exactly one event_out=3'b010 for 1 cycle, 2 cycles after the sampling edge, followed by 000; pending returns to 0.
- Priority: stim_in bits 0, 4 and 6 rise together → codes issued in order 3'b111, 3'b101, 3'b001, each followed by one 000 gap cycle.
- Overflow: raise bit2, drop it, raise it again while bit2 is still pending behind a higher-priority grant → overflow=1 and it stays 1; bit2 is issued once.
- Set-wins race: bit3 re-rises on the same cycle it is granted → no overflow; code 3'b100 is issued twice.
- Parameter sweep: HOLD_CYCLES=3, GAP_CYCLES=0, bits 5 and 1 pending → 3'b110 for 3 cycles, then 3'b010 immediately for 3 cycles, then 000.
